// File: rtl/core_dispatcher_pkg.sv
// Shared sizes, bus types and FSM encodings for the core-array dispatcher.
package core_dispatcher_pkg;

  // Core array geometry
  localparam int NUM_OF_CORES  = 4;
  localparam int REG_SIZE      = 8;
  localparam int INSN_SIZE     = 8;
  localparam int INSN_PER_BUS  = 4;
  localparam int INSN_BUS_SIZE = INSN_SIZE * INSN_PER_BUS;
  localparam int REG_BUS_SIZE  = REG_SIZE * NUM_OF_CORES;

  // Bus shapes: one bit per core, packed per-core registers, instruction image
  typedef logic [NUM_OF_CORES-1:0]  cores_t;
  typedef logic [REG_BUS_SIZE-1:0]  reg_bus_t;
  typedef logic [INSN_BUS_SIZE-1:0] insn_bus_t;

  // Dispatcher sequencing states
  typedef enum logic [2:0] {
    DISP_STATE_IDLE  = 3'd0,
    DISP_STATE_LOAD  = 3'd1,
    DISP_STATE_START = 3'd2,
    DISP_STATE_GUARD = 3'd3,
    DISP_STATE_WAIT  = 3'd4,
    DISP_STATE_DONE  = 3'd5
  } disp_state_e;

  // True when every launched core reports Ready; unlaunched cores are ignored
  function automatic logic all_ready(input cores_t ready, input cores_t mask);
    return (ready & mask) == mask;
  endfunction

  // Per-core R0 load strobe: only launched cores with a seed get one
  function automatic cores_t r0_strobe(input cores_t mask, input cores_t r0_en);
    return mask & r0_en;
  endfunction

endpackage

// File: rtl/core_dispatcher_watchdog.sv
// Load/enable/expire counter used for both the post-Start guard window and
// the WAIT-phase watchdog.
module disp_watchdog #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  // Counter: load restarts from zero, enable advances by one
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset || load) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (count == limit);

endmodule

// File: rtl/core_dispatcher.sv
// Sequences one task onto the core array: latch, load the shared buses,
// pulse Start, ignore stale Ready during the guard window, wait for the
// launched cores, then pulse done (with timeout_err if the watchdog fired).
import core_dispatcher_pkg::*;

module core_dispatcher #(
  parameter int GUARD_CYCLES = 1,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      task_valid,
  output logic      task_ready,
  input  cores_t    task_mask,
  input  cores_t    task_r0_en,
  input  reg_bus_t  task_r0_data,
  input  insn_bus_t task_insn,
  output insn_bus_t insn_data,
  output cores_t    init_R0_flag,
  output reg_bus_t  init_R0_data,
  output cores_t    Start,
  input  cores_t    Ready,
  output logic      busy,
  output logic      done,
  output logic      timeout_err
);

  // Counter compare values; a zero guard or zero timeout never reaches them
  localparam logic [CNT_W-1:0] GUARD_LIM =
    (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] TIMEOUT_LIM =
    (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic WATCHDOG_ON = (TIMEOUT > 0);

  disp_state_e state;

  // Task captured at transfer; held until the next transfer
  cores_t    mask_q;
  cores_t    r0_en_q;
  reg_bus_t  r0_q;
  insn_bus_t insn_q;

  // Shared counter controls
  logic             wd_load;
  logic             wd_en;
  logic [CNT_W-1:0] wd_limit;
  logic             wd_hit;
  logic             in_guard;
  logic             in_wait;
  logic             cores_done;
  logic             timed_out;

  assign in_guard   = (state == DISP_STATE_GUARD);
  assign in_wait    = (state == DISP_STATE_WAIT);
  assign cores_done = all_ready(Ready, mask_q);
  assign timed_out  = WATCHDOG_ON && in_wait && wd_hit;

  // Counter runs through GUARD and WAIT, restarting on entry to each phase
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    wd_en    = 1'b0;
    wd_load  = 1'b1;
    wd_limit = TIMEOUT_LIM;
    if (in_guard) begin
      wd_en    = 1'b1;
      wd_load  = wd_hit;
      wd_limit = GUARD_LIM;
    end else if (in_wait) begin
      wd_en    = 1'b1;
      wd_load  = 1'b0;
    end
  end

  disp_watchdog #(
    .CNT_W (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .load   (wd_load),
    .en     (wd_en),
    .limit  (wd_limit),
    .expire (wd_hit)
  );

  // Accept only in IDLE, and never while reset is asserted
  assign task_ready = (state == DISP_STATE_IDLE) && !reset;
  assign busy       = (state != DISP_STATE_IDLE);

  // Dispatcher FSM with registered strobes and bus images
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= DISP_STATE_IDLE;
      mask_q       <= '0;
      r0_en_q      <= '0;
      r0_q         <= '0;
      insn_q       <= '0;
      insn_data    <= '0;
      init_R0_data <= '0;
      init_R0_flag <= '0;
      Start        <= '0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // Strobes are single-cycle; set only on the transition into their state
      Start        <= '0;
      init_R0_flag <= '0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;

      case (state)
        DISP_STATE_IDLE: begin
          if (task_valid) begin
            mask_q  <= task_mask;
            r0_en_q <= task_r0_en;
            r0_q    <= task_r0_data;
            insn_q  <= task_insn;
            if (task_mask == '0) begin
              // Nothing to launch: complete immediately without touching buses
              state <= DISP_STATE_DONE;
              done  <= 1'b1;
            end else begin
              state <= DISP_STATE_LOAD;
            end
          end
        end

        DISP_STATE_LOAD: begin
          insn_data    <= insn_q;
          init_R0_data <= r0_q;
          Start        <= mask_q;
          init_R0_flag <= r0_strobe(mask_q, r0_en_q);
          state        <= DISP_STATE_START;
        end

        DISP_STATE_START: begin
          state <= (GUARD_CYCLES > 0) ? DISP_STATE_GUARD : DISP_STATE_WAIT;
        end

        DISP_STATE_GUARD: begin
          // Ready is still stale from the previous run here
          if (wd_hit) begin
            state <= DISP_STATE_WAIT;
          end
        end

        DISP_STATE_WAIT: begin
          if (cores_done) begin
            state <= DISP_STATE_DONE;
            done  <= 1'b1;
          end else if (timed_out) begin
            state       <= DISP_STATE_DONE;
            done        <= 1'b1;
            timeout_err <= 1'b1;
          end
        end

        DISP_STATE_DONE: begin
          state <= DISP_STATE_IDLE;
        end

        default: begin
          state <= DISP_STATE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_dispatcher.sv
// Directed bench for core_dispatcher: Ready is driven as a Core array would,
// stale-high through the guard window, low while running, high when finished.
import core_dispatcher_pkg::*;

module tb_core_dispatcher;

  logic      clk = 1'b0;
  logic      reset;
  logic      task_valid;
  logic      task_ready;
  cores_t    task_mask;
  cores_t    task_r0_en;
  reg_bus_t  task_r0_data;
  insn_bus_t task_insn;
  insn_bus_t insn_data;
  cores_t    init_R0_flag;
  reg_bus_t  init_R0_data;
  cores_t    Start;
  cores_t    Ready;
  logic      busy;
  logic      done;
  logic      timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_dispatcher #(
    .GUARD_CYCLES (1),
    .TIMEOUT      (20),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .task_valid   (task_valid),
    .task_ready   (task_ready),
    .task_mask    (task_mask),
    .task_r0_en   (task_r0_en),
    .task_r0_data (task_r0_data),
    .task_insn    (task_insn),
    .insn_data    (insn_data),
    .init_R0_flag (init_R0_flag),
    .init_R0_data (init_R0_data),
    .Start        (Start),
    .Ready        (Ready),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input cores_t m, input cores_t en, input reg_bus_t d, input insn_bus_t i);
    task_valid   = 1'b1;
    task_mask    = m;
    task_r0_en   = en;
    task_r0_data = d;
    task_insn    = i;
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    task_valid   = 1'b0;
    task_mask    = '0;
    task_r0_en   = '0;
    task_r0_data = '0;
    task_insn    = '0;
    Ready        = 4'b1111;

    // Reset state
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_start", Start, 0);
    check("rst_insn", insn_data, 0);
    check("rst_flag", init_R0_flag, 0);
    check("rst_ready_in_reset", task_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_task_ready", task_ready, 1);

    // Test 1: single core, seeded R0
    offer(4'b0001, 4'b0001, 32'h0000_0003, 32'hA1B2_C3D4);
    step();                                   // LOAD
    task_valid = 1'b0;
    check("t1_load_busy", busy, 1);
    check("t1_load_start", Start, 0);
    check("t1_load_insn_old", insn_data, 0);
    check("t1_load_tready", task_ready, 0);
    step();                                   // START
    check("t1_start", Start, 4'b0001);
    check("t1_flag", init_R0_flag, 4'b0001);
    check("t1_insn", insn_data, 32'hA1B2_C3D4);
    check("t1_r0", init_R0_data, 32'h0000_0003);
    step();                                   // GUARD, Ready still stale high
    check("t1_guard_start", Start, 0);
    check("t1_guard_flag", init_R0_flag, 0);
    check("t1_guard_done", done, 0);
    step();                                   // WAIT 1
    Ready = 4'b1110;
    check("t1_wait1_done", done, 0);
    step();                                   // WAIT 2
    check("t1_wait2_done", done, 0);
    Ready = 4'b1111;
    step();                                   // DONE
    check("t1_done", done, 1);
    check("t1_terr", timeout_err, 0);
    step();                                   // IDLE
    check("t1_idle_done", done, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_tready", task_ready, 1);
    check("t1_insn_hold", insn_data, 32'hA1B2_C3D4);

    // Test 2: all four cores, done only after the last Ready
    offer(4'b1111, 4'b1111, 32'h0403_0201, 32'h1122_3344);
    step();                                   // LOAD
    task_valid = 1'b0;
    step();                                   // START
    check("t2_start", Start, 4'b1111);
    check("t2_flag", init_R0_flag, 4'b1111);
    check("t2_r0", init_R0_data, 32'h0403_0201);
    step();                                   // GUARD
    step();                                   // WAIT 1
    Ready = 4'b0000;
    step();                                   // WAIT 2
    Ready = 4'b0101;
    step();                                   // WAIT 3
    check("t2_partial_done", done, 0);
    Ready = 4'b0111;
    step();                                   // WAIT 4
    check("t2_three_done", done, 0);
    Ready = 4'b1111;
    step();                                   // DONE
    check("t2_done", done, 1);
    check("t2_terr", timeout_err, 0);
    step();

    // Test 3: empty mask completes one cycle after transfer
    offer(4'b0000, 4'b1111, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    step();                                   // DONE
    task_valid = 1'b0;
    check("t3_done", done, 1);
    check("t3_terr", timeout_err, 0);
    check("t3_start", Start, 0);
    check("t3_tready_busy", task_ready, 0);
    step();                                   // IDLE
    check("t3_tready", task_ready, 1);
    check("t3_done_clear", done, 0);
    check("t3_insn_untouched", insn_data, 32'h1122_3344);

    // Test 4: core never reports Ready, watchdog expires after 20 WAIT cycles
    offer(4'b0010, 4'b0000, 32'h0000_0000, 32'h0000_0055);
    step();                                   // LOAD
    task_valid = 1'b0;
    step();                                   // START
    check("t4_start", Start, 4'b0010);
    check("t4_flag", init_R0_flag, 4'b0000);
    Ready = 4'b0000;
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    // 1 GUARD + 20 WAIT + DONE after the START cycle
    check("t4_latency", n, 22);
    check("t4_terr", timeout_err, 1);
    step();
    check("t4_terr_clear", timeout_err, 0);
    check("t4_idle", busy, 0);
    Ready = 4'b1111;

    // Test 5: reset during WAIT, then a task with unmasked cores not ready
    offer(4'b0011, 4'b0001, 32'h0000_0077, 32'h0000_0066);
    step();                                   // LOAD
    task_valid = 1'b0;
    step();                                   // START
    step();                                   // GUARD
    step();                                   // WAIT 1
    Ready = 4'b0000;
    step();                                   // WAIT 2
    reset = 1'b1;
    step();
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_insn", insn_data, 0);
    check("t5_r0", init_R0_data, 0);
    reset = 1'b0;
    #1;
    check("t5_tready", task_ready, 1);
    step();
    check("t5_no_done", done, 0);
    offer(4'b0011, 4'b0011, 32'h0000_0908, 32'h0000_0099);
    step();                                   // LOAD
    task_valid = 1'b0;
    step();                                   // START
    check("t5b_start", Start, 4'b0011);
    check("t5b_flag", init_R0_flag, 4'b0011);
    step();                                   // GUARD
    step();                                   // WAIT 1
    Ready = 4'b0000;
    step();                                   // WAIT 2
    Ready = 4'b0011;                          // cores 2,3 unlaunched and not ready
    step();                                   // DONE
    check("t5b_done", done, 1);
    check("t5b_terr", timeout_err, 0);
    step();
    Ready = 4'b1111;

    // Test 6: back-to-back with task_valid held high
    offer(4'b0001, 4'b0000, 32'h0000_0000, 32'hAAAA_0001);
    step();                                   // LOAD A
    offer(4'b0100, 4'b0100, 32'h0011_0000, 32'hBBBB_0002);
    check("t6_a_tready", task_ready, 0);
    step();                                   // START A
    check("t6_a_insn", insn_data, 32'hAAAA_0001);
    check("t6_a_start", Start, 4'b0001);
    step();                                   // GUARD A
    check("t6_guard_tready", task_ready, 0);
    step();                                   // WAIT A, all ready
    check("t6_wait_tready", task_ready, 0);
    step();                                   // DONE A
    check("t6_a_done", done, 1);
    check("t6_done_tready", task_ready, 0);
    step();                                   // IDLE, B transfers at next edge
    check("t6_idle_tready", task_ready, 1);
    check("t6_idle_insn", insn_data, 32'hAAAA_0001);
    step();                                   // LOAD B
    task_valid = 1'b0;
    check("t6_b_load_busy", busy, 1);
    check("t6_b_load_insn", insn_data, 32'hAAAA_0001);
    step();                                   // START B
    check("t6_b_insn", insn_data, 32'hBBBB_0002);
    check("t6_b_start", Start, 4'b0100);
    check("t6_b_flag", init_R0_flag, 4'b0100);
    check("t6_b_r0", init_R0_data, 32'h0011_0000);
    step();                                   // GUARD B
    step();                                   // WAIT B
    step();                                   // DONE B
    check("t6_b_done", done, 1);
    step();
    check("t6_b_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
